receiver: RTL and testbench

//  Receive end of the two-flop-synchronised fast 4-phase bundled-data link.

---
 rtl/receiver_pkg.sv | 12 +
 rtl/receiver_rxfsm.sv | 54 +++++
 rtl/receiver.sv | 68 ++++++
 tb/tb_receiver.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared definitions for the bundled-data receive path: word width and
// handshake FSM state encodings.
package receiver_pkg;

  localparam int DEF_DATA_MSB = 7;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACKH = 1'b1
  } rx_state_t;

endpackage

// File: rtl/receiver_rxfsm.sv
// Receive-side 4-phase handshake FSM: decides capture vs. stall, owns the
// ack level (the state bit itself) and the one-cycle rcvd pulse.
module receiver_rxfsm
  import receiver_pkg::*;
(
  input  logic clk_rx,
  input  logic reset,
  input  logic r2,
  input  logic vo,
  input  logic ri,
  output logic capture,
  output logic ack,
  output logic rcvd
);

  rx_state_t state_reg;
  rx_state_t state_next;
  logic      rcvd_reg;

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      state_reg <= RX_IDLE;
      rcvd_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rcvd_reg  <= capture;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        // A full holding register stalls the handshake unless it drains this cycle.
        if (r2 && (!vo || ri)) begin
          capture    = 1'b1;
          state_next = RX_ACKH;
        end
      end
      RX_ACKH: begin
        if (!r2) begin
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  // ack is a registered output: it is exactly the ACKH state flop.
  assign ack  = (state_reg == RX_ACKH);
  assign rcvd = rcvd_reg;

endmodule

// File: rtl/receiver.sv
// Receive end of the bundled-data link: two-flop req synchroniser, handshake
// FSM, one-entry holding register and valid/ready consumer interface.
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_MSB = DEF_DATA_MSB
) (
  input  logic              clk_rx,
  input  logic              reset,
  input  logic              req,
  input  logic [DATA_MSB:0] data,
  output logic              ack,
  output logic [DATA_MSB:0] rdata,
  output logic              vo,
  input  logic              ri,
  output logic              rcvd
);

  logic              r1_reg;
  logic              r2_reg;
  logic              capture;
  logic              vo_reg;
  logic [DATA_MSB:0] rdata_reg;

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      r1_reg <= 1'b0;
      r2_reg <= 1'b0;
    end else begin
      r1_reg <= req;
      r2_reg <= r1_reg;
    end
  end

  receiver_rxfsm u_rxfsm (
    .clk_rx  (clk_rx),
    .reset   (reset),
    .r2      (r2_reg),
    .vo      (vo_reg),
    .ri      (ri),
    .capture (capture),
    .ack     (ack),
    .rcvd    (rcvd)
  );

  // data is bundled with req, so it is only looked at in the capture cycle.
  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else if (capture) begin
      rdata_reg <= data;
    end
  end

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      vo_reg <= 1'b0;
    end else if (capture) begin
      vo_reg <= 1'b1;
    end else if (vo_reg && ri) begin
      vo_reg <= 1'b0;
    end
  end

  assign rdata = rdata_reg;
  assign vo    = vo_reg;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed handshake scenarios plus a
// randomised asynchronous transmitter with a random consumer.
module tb_receiver;

  localparam int W = 8;

  logic         clk_rx = 1'b0;
  logic         reset  = 1'b1;
  logic         req    = 1'b0;
  logic         ri     = 1'b0;
  logic [W-1:0] data   = '0;
  logic         ack;
  logic         vo;
  logic         rcvd;
  logic [W-1:0] rdata;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] cap_log[$];
  logic [W-1:0] cons_log[$];
  logic [W-1:0] sent[$];

  receiver dut (
    .clk_rx (clk_rx),
    .reset  (reset),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .rdata  (rdata),
    .vo     (vo),
    .ri     (ri),
    .rcvd   (rcvd)
  );

  always #5 clk_rx = ~clk_rx;

  // Every rcvd pulse logs the word that was just captured.
  always @(posedge clk_rx) begin
    #1;
    if (rcvd === 1'b1) cap_log.push_back(rdata);
  end

  // A word is consumed when vo and ri are both high going into an edge.
  always @(negedge clk_rx) begin
    if (reset === 1'b1 && vo === 1'b1 && ri === 1'b1) cons_log.push_back(rdata);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_rx);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, output logic ok);
    int n;
    n = 0;
    while (ack !== lvl && n < 200) begin
      tick();
      n++;
    end
    ok = (ack === lvl);
  endtask

  // Clock-synchronous transmitter for the directed scenarios.
  task automatic send_word(input logic [W-1:0] d, output logic ok);
    logic ok1, ok2;
    data = d;
    req  = 1'b1;
    sent.push_back(d);
    wait_ack(1'b1, ok1);
    req = 1'b0;
    wait_ack(1'b0, ok2);
    ok = ok1 && ok2;
    $display("tx word %02h handshake %s", d, ok ? "complete" : "timed out");
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick(2);
    checks++;
    if ({ack, vo, rcvd} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: ack/vo/rcvd=%b want 000", {ack, vo, rcvd});
    end
    checks++;
    if (rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdata: got %02h want 00", rdata);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    data = 8'hA5;
    req  = 1'b1;
    ri   = 1'b1;
    tick(2);
    checks++;
    if (ack !== 1'b0 || vo !== 1'b0) begin
      failures++;
      $display("FAIL single_early: ack=%b vo=%b want 0 0", ack, vo);
    end
    tick(1);
    checks++;
    if ({ack, vo, rcvd} !== 3'b111 || rdata !== 8'hA5) begin
      failures++;
      $display("FAIL single_capture: ack/vo/rcvd=%b rdata=%02h want 111 a5", {ack, vo, rcvd}, rdata);
    end
    req = 1'b0;
    tick(1);
    checks++;
    if (vo !== 1'b0 || rcvd !== 1'b0) begin
      failures++;
      $display("FAIL single_consume: vo=%b rcvd=%b want 0 0", vo, rcvd);
    end
    tick(1);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL single_ack_hold: got %b want 1", ack);
    end
    tick(1);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL single_ack_fall: got %b want 0", ack);
    end
    ri = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [W-1:0] exp_w;
    cap_log.delete();
    ri = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_w = W'(i);
      send_word(exp_w, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_handshake: word %02h ack timeout, ack=%b", exp_w, ack);
      end
    end
    tick(2);
    checks++;
    if (cap_log.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d rcvd pulses want 3", cap_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_w = W'(i + 1);
        checks++;
        if (cap_log[i] !== exp_w) begin
          failures++;
          $display("FAIL b2b_order: slot %0d got %02h want %02h", i, cap_log[i], exp_w);
        end
      end
    end
    checks++;
    if (ack !== 1'b0 || vo !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: ack=%b vo=%b want 0 0", ack, vo);
    end
    ri = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ok;
    int bad_stall;
    ri = 1'b0;
    send_word(8'h11, ok);
    checks++;
    if (!ok || vo !== 1'b1 || rdata !== 8'h11) begin
      failures++;
      $display("FAIL bp_first: ok=%b vo=%b rdata=%02h want 1 1 11", ok, vo, rdata);
    end
    data = 8'h22;
    req  = 1'b1;
    bad_stall = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (ack !== 1'b0 || rcvd !== 1'b0) bad_stall++;
    end
    checks++;
    if (bad_stall != 0) begin
      failures++;
      $display("FAIL bp_stall: ack/rcvd high in %0d stall cycles want 0", bad_stall);
    end
    checks++;
    if (rdata !== 8'h11 || vo !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: rdata=%02h vo=%b want 11 1", rdata, vo);
    end
    ri = 1'b1;
    tick(1);
    checks++;
    if ({ack, vo, rcvd} !== 3'b111 || rdata !== 8'h22) begin
      failures++;
      $display("FAIL bp_release: ack/vo/rcvd=%b rdata=%02h want 111 22", {ack, vo, rcvd}, rdata);
    end
    checks++;
    if (cons_log.size() == 0 || cons_log[$] !== 8'h11) begin
      failures++;
      $display("FAIL bp_consumed: last consumed=%02h want 11", cons_log.size() ? cons_log[$] : 8'hxx);
    end
    ri  = 1'b0;
    req = 1'b0;
    wait_ack(1'b0, ok);
    checks++;
    if (!ok || vo !== 1'b1 || rdata !== 8'h22) begin
      failures++;
      $display("FAIL bp_after: ok=%b vo=%b rdata=%02h want 1 1 22", ok, vo, rdata);
    end
  endtask

  task automatic test_consume();
    ri = 1'b1;
    tick(1);
    ri = 1'b0;
    checks++;
    if (vo !== 1'b0 || rdata !== 8'h22 || ack !== 1'b0) begin
      failures++;
      $display("FAIL consume: vo=%b rdata=%02h ack=%b want 0 22 0", vo, rdata, ack);
    end
    tick(2);
    checks++;
    if (vo !== 1'b0 || rcvd !== 1'b0) begin
      failures++;
      $display("FAIL consume_idle: vo=%b rcvd=%b want 0 0", vo, rcvd);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    ri   = 1'b0;
    data = 8'h5A;
    req  = 1'b1;
    wait_ack(1'b1, ok);
    checks++;
    if (!ok || vo !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup: ok=%b vo=%b want 1 1", ok, vo);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({ack, vo, rcvd} !== 3'b000 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async: ack/vo/rcvd=%b rdata=%02h want 000 00", {ack, vo, rcvd}, rdata);
    end
    tick(2);
    cap_log.delete();
    reset = 1'b1;
    tick(8);
    checks++;
    if (cap_log.size() != 1 || rdata !== 8'h5A || ack !== 1'b1 || vo !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_recapture: pulses=%0d rdata=%02h ack=%b vo=%b want 1 5a 1 1",
               cap_log.size(), rdata, ack, vo);
    end
    req = 1'b0;
    ri  = 1'b1;
    wait_ack(1'b0, ok);
    tick(1);
    ri = 1'b0;
    checks++;
    if (!ok || vo !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drain: ok=%b vo=%b want 1 0", ok, vo);
    end
  endtask

  // Transmitter on an unrelated time base (3..30 units per tx clock) against a random consumer.
  task automatic test_random();
    logic         done;
    int           timeouts;
    int           tp;
    int           n;
    int           bad;
    logic [W-1:0] d;
    sent.delete();
    cons_log.delete();
    cap_log.delete();
    done     = 1'b0;
    timeouts = 0;
    fork
      begin
        for (int w = 0; w < 40; w++) begin
          tp = int'($urandom_range(3, 30));
          d  = W'($urandom);
          #(tp * int'($urandom_range(0, 3)) + int'($urandom_range(1, 4)));
          data = d;
          req  = 1'b1;
          sent.push_back(d);
          n = 0;
          while (ack !== 1'b1 && n < 5000) begin
            #1;
            n++;
          end
          if (ack !== 1'b1) timeouts++;
          #(tp * int'($urandom_range(1, 2)));
          req = 1'b0;
          n = 0;
          while (ack !== 1'b0 && n < 5000) begin
            #1;
            n++;
          end
          if (ack !== 1'b0) timeouts++;
          data = W'($urandom);
          $display("tx word %02h (tx period %0d) handshake done", d, tp);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_rx);
          #1;
          ri = ($urandom_range(0, 2) != 0);
        end
      end
    join
    ri = 1'b1;
    tick(4);
    ri = 1'b0;
    checks++;
    if (timeouts != 0) begin
      failures++;
      $display("FAIL rand_timeout: %0d handshake waits expired want 0", timeouts);
    end
    checks++;
    if (cap_log.size() != sent.size()) begin
      failures++;
      $display("FAIL rand_rcvd_count: got %0d want %0d", cap_log.size(), sent.size());
    end
    checks++;
    if (cons_log.size() != sent.size()) begin
      failures++;
      $display("FAIL rand_consumed_count: got %0d want %0d", cons_log.size(), sent.size());
    end else begin
      bad = 0;
      for (int i = 0; i < sent.size(); i++) begin
        if (cons_log[i] !== sent[i]) begin
          if (bad == 0) $display("FAIL rand_order: slot %0d got %02h want %02h", i, cons_log[i], sent[i]);
          bad++;
        end
      end
      checks++;
      if (bad != 0) failures++;
    end
    checks++;
    if (vo !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL rand_final_idle: vo=%b ack=%b want 0 0", vo, ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_consume();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
